bf16_accum: RTL and testbench



---
 rtl/bf16_pkg.sv | 41 ++++
 rtl/bf16_accum_if.sv | 22 ++
 rtl/bf16_lzc.sv | 20 ++
 rtl/bf16_accum.sv | 168 ++++++++++++++++
 tb/tb_bf16_accum.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared bfloat16 field widths, FSM encoding and operand unpacking for the accumulator.
package bf16_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 7;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned EXP_MAX = 2 * BIAS;
    localparam logic [14:0] BF16_MAX_FINITE = 15'h7F7F;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        OUT   = 3'd4
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  ex;
        logic [FRAC_W:0]   sig;
    } bf16_unpacked_t;

    // Subnormals flush to +0; exponent 255 is clamped to the largest finite magnitude.
    function automatic bf16_unpacked_t bf16_unpack(input logic [0:15] w);
        bf16_unpacked_t u;
        u.sign = w[0];
        u.ex   = w[1:8];
        u.sig  = {1'b1, w[9:15]};
        if (w[1:8] == '0) begin
            u.sign = 1'b0;
            u.ex   = '0;
            u.sig  = '0;
        end else if (w[1:8] == '1) begin
            u.ex  = BF16_MAX_FINITE[14:7];
            u.sig = {1'b1, BF16_MAX_FINITE[6:0]};
        end
        return u;
    endfunction

endpackage

// File: rtl/bf16_accum_if.sv
// Product stream in, sum stream out, both valid/ready.
interface bf16_accum_if;

    logic        in_valid;
    logic        in_ready;
    logic [0:15] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [0:15] out_data;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/bf16_lzc.sv
// Combinational leading-zero count; an all-zero input reports W.
module bf16_lzc #(
    parameter int unsigned W     = 12,
    parameter int unsigned CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] count_c
);

    // Ascending scan: the highest set bit is the last to write.
    always_comb begin
        count_c = CNT_W'(W);
        for (int i = 0; i < int'(W); i++) begin
            if (din[i]) begin
                count_c = CNT_W'(int'(W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/bf16_accum.sv
// Sequential bf16 accumulator: folds a product stream into an extended-precision sum,
// emitting one truncated bf16 result per stream.
module bf16_accum
    import bf16_pkg::*;
#(
    parameter int unsigned GUARD_BITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bf16_accum_if.slave   bus
);

    localparam int unsigned SIG_W = FRAC_W + 1 + GUARD_BITS;
    localparam int unsigned SUM_W = SIG_W + 1;
    localparam int unsigned CNT_W = $clog2(SUM_W + 1);
    localparam int unsigned EXT_W = EXP_W + 2;

    state_t state, state_nxt;

    logic [0:15]       op_q;
    logic              last_q;
    logic              acc_sign;
    logic [EXP_W-1:0]  acc_exp;
    logic [SIG_W-1:0]  acc_sig;
    logic [EXP_W-1:0]  al_exp;
    logic              al_sign_x, al_sign_y;
    logic [SIG_W-1:0]  al_x, al_y;
    logic              sum_sign;
    logic [EXP_W-1:0]  sum_exp;
    logic [SUM_W-1:0]  sum_q;

    bf16_unpacked_t    opu;
    logic [SIG_W-1:0]  b_sig, small_sig, shifted;
    logic [EXP_W-1:0]  diff;
    logic              a_ge;
    logic [SUM_W-1:0]  add_res;
    logic              add_sign;
    logic [CNT_W-1:0]  lz;
    logic [EXT_W-1:0]  n_exp;
    logic [SIG_W-1:0]  n_sig;
    logic              r_sign;
    logic [EXP_W-1:0]  r_exp;
    logic [SIG_W-1:0]  r_sig;

    bf16_lzc #(.W(SUM_W), .CNT_W(CNT_W)) u_lzc (
        .din     (sum_q),
        .count_c (lz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = ALIGN;
            ALIGN:   state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    state_nxt = last_q ? OUT : IDLE;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            OUT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = {acc_sign, acc_exp, acc_sig[SIG_W-2 -: FRAC_W]};
            end
            default: ;
        endcase
    end

    // Align: larger exponent is the reference, the other significand is shifted down.
    always_comb begin
        opu       = bf16_unpack(op_q);
        b_sig     = {opu.sig, {GUARD_BITS{1'b0}}};
        a_ge      = acc_exp >= opu.ex;
        diff      = a_ge ? (acc_exp - opu.ex) : (opu.ex - acc_exp);
        small_sig = a_ge ? b_sig : acc_sig;
        shifted   = (diff > EXP_W'(SIG_W)) ? '0 : (small_sig >> diff);
    end

    always_comb begin
        add_sign = al_sign_x;
        if (al_sign_x == al_sign_y) begin
            add_res = {1'b0, al_x} + {1'b0, al_y};
        end else if (al_x >= al_y) begin
            add_res = {1'b0, al_x} - {1'b0, al_y};
        end else begin
            add_res  = {1'b0, al_y} - {1'b0, al_x};
            add_sign = al_sign_y;
        end
    end

    // Normalise: a carry gives lz=0, so the exponent update is uniformly +1-lz.
    always_comb begin
        n_exp  = EXT_W'(sum_exp) + EXT_W'(1) - EXT_W'(lz);
        n_sig  = sum_q[SUM_W-1] ? sum_q[SUM_W-1:1] : SIG_W'(sum_q << (lz - CNT_W'(1)));
        r_sign = sum_sign;
        r_exp  = n_exp[EXP_W-1:0];
        r_sig  = n_sig;
        if (sum_q == '0 || n_exp[EXT_W-1] || n_exp == '0) begin
            r_sign = 1'b0;
            r_exp  = '0;
            r_sig  = '0;
        end else if (n_exp > EXT_W'(EXP_MAX)) begin
            r_exp = EXP_W'(EXP_MAX);
            r_sig = {1'b1, BF16_MAX_FINITE[6:0], {GUARD_BITS{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            last_q    <= 1'b0;
            acc_sign  <= 1'b0;
            acc_exp   <= '0;
            acc_sig   <= '0;
            al_exp    <= '0;
            al_sign_x <= 1'b0;
            al_sign_y <= 1'b0;
            al_x      <= '0;
            al_y      <= '0;
            sum_sign  <= 1'b0;
            sum_exp   <= '0;
            sum_q     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_q   <= bus.in_data;
                    last_q <= bus.in_last;
                end
                ALIGN: begin
                    al_exp    <= a_ge ? acc_exp : opu.ex;
                    al_sign_x <= a_ge ? acc_sign : opu.sign;
                    al_sign_y <= a_ge ? opu.sign : acc_sign;
                    al_x      <= a_ge ? acc_sig : b_sig;
                    al_y      <= shifted;
                end
                ADD: begin
                    sum_sign <= add_sign;
                    sum_exp  <= al_exp;
                    sum_q    <= add_res;
                end
                NORM: begin
                    acc_sign <= r_sign;
                    acc_exp  <= r_exp;
                    acc_sig  <= r_sig;
                end
                OUT: if (bus.out_ready) begin
                    acc_sign <= 1'b0;
                    acc_exp  <= '0;
                    acc_sig  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_accum.sv
// Directed and random stream bench for bf16_accum against an integer-significand reference model.
module tb_bf16_accum;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   m_sign, m_exp, m_sig;

    always #5 clk = ~clk;

    bf16_accum_if bus();

    bf16_accum #(.GUARD_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        m_sign = 0;
        m_exp  = 0;
        m_sig  = 0;
    endtask

    // Value = sig * 2^(exp-127-10); sig carries hidden bit, 7 fraction bits and 3 guard bits.
    task automatic model_add(input logic [15:0] w);
        int s, e, f, m, ma, d, v;
        s = int'(w[15]);
        e = int'(w[14:7]);
        f = int'(w[6:0]);
        if (e == 0) begin
            s = 0; m = 0;
        end else if (e == 255) begin
            e = 254; m = 255 * 8;
        end else begin
            m = (128 + f) * 8;
        end
        if (m_exp >= e) begin
            d  = m_exp - e;
            m  = (d > 11) ? 0 : (m >> d);
            ma = m_sig;
            e  = m_exp;
        end else begin
            d  = e - m_exp;
            ma = (d > 11) ? 0 : (m_sig >> d);
        end
        v = (m_sign != 0 ? -ma : ma) + (s != 0 ? -m : m);
        s = (v < 0) ? 1 : 0;
        m = (v < 0) ? -v : v;
        if (m >= 2048) begin
            m = m >> 1;
            e++;
        end
        while (m != 0 && m < 1024) begin
            m = m << 1;
            e--;
        end
        if (m == 0 || e <= 0) begin
            model_clear();
        end else if (e > 254) begin
            m_sign = s; m_exp = 254; m_sig = 255 * 8;
        end else begin
            m_sign = s; m_exp = e; m_sig = m;
        end
    endtask

    function automatic logic [15:0] model_result();
        return {1'(m_sign), 8'(m_exp), 7'(m_sig >> 3)};
    endfunction

    function automatic logic [15:0] rand_word();
        logic [7:0] e;
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0)      e = 8'd0;
        else if (r == 1) e = 8'd255;
        else if (r == 2) e = 8'd254;
        else             e = 8'($urandom_range(118, 136));
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    task automatic send(input logic [15:0] w, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.in_last  = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        model_add(w);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic recv(input string tag, input logic [15:0] exp_v);
        wait_out();
        check({tag, "_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp_v));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus.out_valid), 0);
        model_clear();
    endtask

    initial begin
        int accepts;
        int n;
        logic [15:0] held;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);

        // 1.0 + 2.0 with output latency from the last accept
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b1);
        check("busy_in_ready", 32'(bus.in_ready), 0);
        repeat (2) @(posedge clk);
        #1 check("lat_early", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1 check("lat_rise", 32'(bus.out_valid), 1);
        recv("one_plus_two", 16'h4040);

        send(16'h3F00, 1'b1);  recv("half", 16'h3F00);
        send(16'h0001, 1'b1);  recv("subnormal", 16'h0000);
        send(16'h3F80, 1'b0);  send(16'hBF80, 1'b1);  recv("cancel", 16'h0000);
        send(16'h4040, 1'b0);  send(16'hC000, 1'b1);  recv("left_norm", 16'h3F80);
        send(16'h4B80, 1'b0);  send(16'h3F80, 1'b1);  recv("shift_out", 16'h4B80);
        send(16'h7F7F, 1'b0);  send(16'h7F7F, 1'b1);  recv("saturate", 16'h7F7F);

        // Backpressure: result held while the consumer stalls
        send(16'h4000, 1'b0);
        send(16'h3F80, 1'b1);
        wait_out();
        held = 16'h4040;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_data", 32'(bus.out_data), 32'(held));
            check("bp_in_ready", 32'(bus.in_ready), 0);
            @(negedge clk);
        end
        recv("bp_release", held);
        send(16'h3F80, 1'b1);  recv("cleared", 16'h3F80);

        // in_valid held high: one accept every four cycles
        accepts = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h3F80;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) begin
                accepts++;
                model_add(16'h3F80);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("accept_rate", 32'(accepts), 5);
        send(16'h0000, 1'b1);  recv("stream5", 16'h40A0);

        // Reset during ADD of a three-word stream
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h4040, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 0);
        check("midrst_data", 32'(bus.out_data), 0);
        model_clear();
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus.in_ready), 1);
        send(16'h4000, 1'b1);  recv("after_reset", 16'h4000);

        // Random streams of 1-4 words
        for (int s = 0; s < 60; s++) begin
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) begin
                send(rand_word(), 1'(k == n - 1));
            end
            recv("rand", model_result());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
